// File: rtl/dp_ram_march_ctrl.sv
// ---------------------------------------------------------------------------
// dp_ram_march_ctrl
//
// Self-test sequencer for a dual-port RAM. While a test runs it owns the
// RAM's read and write ports and executes a four-element march:
//   M0  ascending   write P0
//   M1  ascending   read (expect P0), write P1
//   M2  descending  read (expect P1), write P0
//   M3  ascending   read (expect P0)
// with P0 = all-zeros and P1 = all-ones. Every read is compared against the
// expected background; pass/fail status and first-failure diagnostics are
// kept until the next test starts.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               single-cycle test request, honoured only when idle
//   abort               stops a running test at the next edge
//   rd_en, rd_addr      RAM read port (data_out valid one cycle after rd_en)
//   wr_en, wr_addr      RAM write port
//   data_in             RAM write data
//   data_mask_in        RAM write bit mask, always all-ones
//   data_out            RAM read data
//   busy                test in progress; selects this block at the RAM mux
//   done                sticky: last test ran to completion
//   fail                sticky: last test saw at least one miscompare
//   fail_addr           address of the first miscompare
//   fail_syndrome       data_out ^ expected at the first miscompare
//   fail_count          saturating miscompare counter
//   cur_elem            march element currently running
// ---------------------------------------------------------------------------
module dp_ram_march_ctrl #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter bit STOP_ON_FAIL   = 1'b0,
    parameter int FAIL_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic                      wr_en,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0]     data_in,
    output logic [DATA_WIDTH-1:0]     data_mask_in,
    input  logic [DATA_WIDTH-1:0]     data_out,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [ADDR_WIDTH-1:0]     fail_addr,
    output logic [DATA_WIDTH-1:0]     fail_syndrome,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic [1:0]                cur_elem
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        CHK
    } state_t;

    state_t                    state, state_next;
    logic [1:0]                elem, elem_next;
    logic [ADDR_WIDTH-1:0]     addr, addr_next;
    logic                      done_next, fail_next;
    logic [ADDR_WIDTH-1:0]     fail_addr_next;
    logic [DATA_WIDTH-1:0]     fail_syndrome_next;
    logic [FAIL_CNT_WIDTH-1:0] fail_count_next;

    logic [DATA_WIDTH-1:0]     expected;
    logic                      miscompare;
    logic                      elem_last_addr;

    // RAM controls come only from registered state/address, so nothing on
    // start/abort/data_out can reach them combinationally. Writes happen in
    // WR (M0) and in the CHK cycle of M1/M2, never in the same cycle as RD.
    assign rd_en        = (state == RD);
    assign wr_en        = (state == WR) ||
                          ((state == CHK) && ((elem == 2'd1) || (elem == 2'd2)));
    assign rd_addr      = addr;
    assign wr_addr      = addr;
    assign data_in      = ((state == CHK) && (elem == 2'd1)) ? '1 : '0;
    assign data_mask_in = '1;
    assign busy         = (state != IDLE);
    assign cur_elem     = elem;

    // Only M2 reads back P1; M1 and M3 expect P0. M2 is the one descending
    // element, so its final address is 0 instead of DEPTH-1.
    assign expected       = (elem == 2'd2) ? '1 : '0;
    assign miscompare     = (state == CHK) && (data_out != expected);
    assign elem_last_addr = (elem == 2'd2) ? (addr == '0) : (addr == LAST_ADDR);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            elem          <= 2'd0;
            addr          <= '0;
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_addr     <= '0;
            fail_syndrome <= '0;
            fail_count    <= '0;
        end else begin
            state         <= state_next;
            elem          <= elem_next;
            addr          <= addr_next;
            done          <= done_next;
            fail          <= fail_next;
            fail_addr     <= fail_addr_next;
            fail_syndrome <= fail_syndrome_next;
            fail_count    <= fail_count_next;
        end
    end

    // Next-state, address sequencing and diagnostic capture.
    always_comb begin
        state_next         = state;
        elem_next          = elem;
        addr_next          = addr;
        done_next          = done;
        fail_next          = fail;
        fail_addr_next     = fail_addr;
        fail_syndrome_next = fail_syndrome;
        fail_count_next    = fail_count;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next         = WR;
                    elem_next          = 2'd0;
                    addr_next          = '0;
                    done_next          = 1'b0;
                    fail_next          = 1'b0;
                    fail_addr_next     = '0;
                    fail_syndrome_next = '0;
                    fail_count_next    = '0;
                end
            end
            WR: begin
                if (addr == LAST_ADDR) begin
                    state_next = RD;
                    elem_next  = 2'd1;
                    addr_next  = '0;
                end else begin
                    addr_next = addr + 1'b1;
                end
            end
            RD: begin
                state_next = CHK;
            end
            CHK: begin
                if (miscompare) begin
                    fail_next = 1'b1;
                    if (fail_count != '1) begin
                        fail_count_next = fail_count + 1'b1;
                    end
                    // Only the first miscompare of a test is recorded.
                    if (fail_count == '0) begin
                        fail_addr_next     = addr;
                        fail_syndrome_next = data_out ^ expected;
                    end
                end
                if (miscompare && STOP_ON_FAIL) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    addr_next  = '0;
                end else if (elem_last_addr) begin
                    if (elem == 2'd3) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        addr_next  = '0;
                    end else begin
                        state_next = RD;
                        elem_next  = elem + 2'd1;
                        addr_next  = (elem == 2'd1) ? LAST_ADDR : '0;
                    end
                end else begin
                    state_next = RD;
                    addr_next  = (elem == 2'd2) ? (addr - 1'b1) : (addr + 1'b1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides everything: the test ends unfinished and the
        // diagnostics keep whatever they held before this cycle.
        if (abort && (state != IDLE)) begin
            state_next         = IDLE;
            addr_next          = '0;
            done_next          = 1'b0;
            fail_next          = fail;
            fail_addr_next     = fail_addr;
            fail_syndrome_next = fail_syndrome;
            fail_count_next    = fail_count;
        end
    end

endmodule

// File: tb/tb_dp_ram_march_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dp_ram_march_ctrl
//
// Three controller instances, each with its own behavioural RAM:
//   a : 4 x 8, optional bit0 stuck-at-1 on address 2, runs to completion
//   s : 4 x 8, same fault always present, stops on first failure
//   w : 256 x 8, bit0 stuck-at-1 on addresses 0..149 (300 miscompares)
// Instance a is watched by a scoreboard of expected RAM accesses.
// ---------------------------------------------------------------------------
module tb_dp_ram_march_ctrl;

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    localparam logic [44:0] RESET_VEC = {37'd0, 8'hFF};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fault_a = 1'b0;

    int checks = 0;
    int failures = 0;
    acc_t sb_q[$];

    always #5 clk = ~clk;

    // ---------------- instance a ----------------
    logic       a_start = 1'b0, a_abort = 1'b0;
    logic       a_rd_en, a_wr_en, a_busy, a_done, a_fail;
    logic [1:0] a_rd_addr, a_wr_addr, a_fail_addr, a_cur_elem;
    logic [7:0] a_data_in, a_data_mask_in, a_data_out, a_fail_syndrome, a_fail_count;
    logic [7:0] mem_a [4];

    dp_ram_march_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .STOP_ON_FAIL(1'b0), .FAIL_CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .data_in(a_data_in), .data_mask_in(a_data_mask_in), .data_out(a_data_out),
        .busy(a_busy), .done(a_done), .fail(a_fail), .fail_addr(a_fail_addr),
        .fail_syndrome(a_fail_syndrome), .fail_count(a_fail_count), .cur_elem(a_cur_elem)
    );

    always @(posedge clk) begin
        if (a_wr_en) mem_a[a_wr_addr] <= (mem_a[a_wr_addr] & ~a_data_mask_in) | (a_data_in & a_data_mask_in);
        if (a_rd_en) a_data_out <= mem_a[a_rd_addr] | {7'd0, fault_a && (a_rd_addr == 2'd2)};
    end

    // ---------------- instance s ----------------
    logic       s_start = 1'b0, s_abort = 1'b0;
    logic       s_rd_en, s_wr_en, s_busy, s_done, s_fail;
    logic [1:0] s_rd_addr, s_wr_addr, s_fail_addr, s_cur_elem;
    logic [7:0] s_data_in, s_data_mask_in, s_data_out, s_fail_syndrome, s_fail_count;
    logic [7:0] mem_s [4];

    dp_ram_march_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .STOP_ON_FAIL(1'b1), .FAIL_CNT_WIDTH(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
        .data_in(s_data_in), .data_mask_in(s_data_mask_in), .data_out(s_data_out),
        .busy(s_busy), .done(s_done), .fail(s_fail), .fail_addr(s_fail_addr),
        .fail_syndrome(s_fail_syndrome), .fail_count(s_fail_count), .cur_elem(s_cur_elem)
    );

    always @(posedge clk) begin
        if (s_wr_en) mem_s[s_wr_addr] <= (mem_s[s_wr_addr] & ~s_data_mask_in) | (s_data_in & s_data_mask_in);
        if (s_rd_en) s_data_out <= mem_s[s_rd_addr] | {7'd0, s_rd_addr == 2'd2};
    end

    // ---------------- instance w ----------------
    logic       w_start = 1'b0, w_abort = 1'b0;
    logic       w_rd_en, w_wr_en, w_busy, w_done, w_fail;
    logic [1:0] w_cur_elem;
    logic [7:0] w_rd_addr, w_wr_addr, w_fail_addr;
    logic [7:0] w_data_in, w_data_mask_in, w_data_out, w_fail_syndrome, w_fail_count;
    logic [7:0] mem_w [256];

    dp_ram_march_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STOP_ON_FAIL(1'b0), .FAIL_CNT_WIDTH(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort),
        .rd_en(w_rd_en), .rd_addr(w_rd_addr), .wr_en(w_wr_en), .wr_addr(w_wr_addr),
        .data_in(w_data_in), .data_mask_in(w_data_mask_in), .data_out(w_data_out),
        .busy(w_busy), .done(w_done), .fail(w_fail), .fail_addr(w_fail_addr),
        .fail_syndrome(w_fail_syndrome), .fail_count(w_fail_count), .cur_elem(w_cur_elem)
    );

    always @(posedge clk) begin
        if (w_wr_en) mem_w[w_wr_addr] <= (mem_w[w_wr_addr] & ~w_data_mask_in) | (w_data_in & w_data_mask_in);
        if (w_rd_en) w_data_out <= mem_w[w_rd_addr] | {7'd0, w_rd_addr < 8'd150};
    end

    // ---------------- helpers ----------------
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [44:0] stateVecA();
        return {a_busy, a_done, a_fail, a_rd_en, a_wr_en, a_rd_addr, a_wr_addr, a_data_in,
                a_fail_addr, a_fail_syndrome, a_fail_count, a_cur_elem, a_data_mask_in};
    endfunction

    function automatic logic busyOf(input int which);
        case (which)
            0:       return a_busy;
            1:       return s_busy;
            default: return w_busy;
        endcase
    endfunction

    task automatic setIn(input int which, input logic st, input logic ab);
        case (which)
            0:       begin a_start = st; a_abort = ab; end
            1:       begin s_start = st; s_abort = ab; end
            default: begin w_start = st; w_abort = ab; end
        endcase
    endtask

    // Drives start/abort for one cycle; called and returns on a falling edge.
    task automatic applyStimulus(input int which, input logic st, input logic ab);
        setIn(which, st, ab);
        @(negedge clk);
        setIn(which, 1'b0, 1'b0);
    endtask

    // Counts busy cycles (bounded); optionally pulses start or abort while busy.
    task automatic runAndCount(input int which, input int limit, input int pulse_at,
                               input int abort_at, output int cycles);
        cycles = 0;
        while (busyOf(which) && (cycles < limit)) begin
            setIn(which, cycles == pulse_at, cycles == abort_at);
            cycles++;
            @(negedge clk);
        end
        setIn(which, 1'b0, 1'b0);
    endtask

    // Expected RAM access order of a clean 4-address march, first 'limit' entries.
    task automatic pushMarch(input int limit);
        acc_t seq[$];
        for (int i = 0; i < 4; i++) seq.push_back('{1'b1, 8'(i), 8'h00});
        for (int i = 0; i < 4; i++) begin
            seq.push_back('{1'b0, 8'(i), 8'h00});
            seq.push_back('{1'b1, 8'(i), 8'hFF});
        end
        for (int i = 3; i >= 0; i--) begin
            seq.push_back('{1'b0, 8'(i), 8'h00});
            seq.push_back('{1'b1, 8'(i), 8'h00});
        end
        for (int i = 0; i < 4; i++) seq.push_back('{1'b0, 8'(i), 8'h00});
        for (int i = 0; i < limit && i < seq.size(); i++) sb_q.push_back(seq[i]);
    endtask

    // Scoreboard monitor for instance a: every RAM access pops one expectation.
    always @(negedge clk) begin : mon_a
        logic [18:0] obs;
        logic [18:0] exp_v;
        acc_t        item;
        if (rst_n && (a_rd_en || a_wr_en)) begin
            obs = {a_busy, a_rd_en & a_wr_en, a_wr_en,
                   6'd0, (a_wr_en ? a_wr_addr : a_rd_addr), (a_wr_en ? a_data_in : 8'd0)};
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_access", 64'(sb_q.size()), 64'd1);
            end else begin
                item  = sb_q.pop_front();
                exp_v = {1'b1, 1'b0, item.is_wr, item.addr, (item.is_wr ? item.data : 8'd0)};
                checkOutput("sb_access", 64'(obs), 64'(exp_v));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int n;

        repeat (2) @(negedge clk);
        checkOutput("reset_state", 64'(stateVecA()), 64'(RESET_VEC));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_no_start", 64'(a_busy), 64'd0);

        $display("[TB] clean march");
        pushMarch(24);
        applyStimulus(0, 1'b1, 1'b0);
        runAndCount(0, 100, -1, -1, cyc);
        checkOutput("clean_busy_cycles", 64'(cyc), 64'd28);
        checkOutput("clean_status", 64'({a_busy, a_done, a_fail, a_fail_count}), 64'({1'b0, 1'b1, 1'b0, 8'd0}));
        checkOutput("clean_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] start pulsed while busy");
        pushMarch(24);
        applyStimulus(0, 1'b1, 1'b0);
        runAndCount(0, 100, 5, -1, cyc);
        checkOutput("restart_busy_cycles", 64'(cyc), 64'd28);
        checkOutput("restart_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] start with abort in idle");
        applyStimulus(0, 1'b1, 1'b1);
        checkOutput("start_abort_busy", 64'(a_busy), 64'd0);
        checkOutput("start_abort_done_held", 64'(a_done), 64'd1);

        $display("[TB] stuck-at on address 2, run to completion");
        fault_a = 1'b1;
        pushMarch(24);
        applyStimulus(0, 1'b1, 1'b0);
        runAndCount(0, 100, -1, -1, cyc);
        checkOutput("fault_busy_cycles", 64'(cyc), 64'd28);
        checkOutput("fault_done_fail", 64'({a_done, a_fail}), 64'({1'b1, 1'b1}));
        checkOutput("fault_addr", 64'(a_fail_addr), 64'd2);
        checkOutput("fault_syndrome", 64'(a_fail_syndrome), 64'h01);
        checkOutput("fault_count", 64'(a_fail_count), 64'd2);
        checkOutput("fault_sb_drained", 64'(sb_q.size()), 64'd0);
        fault_a = 1'b0;

        $display("[TB] abort in busy cycle 10");
        pushMarch(11);
        applyStimulus(0, 1'b1, 1'b0);
        runAndCount(0, 100, -1, 10, cyc);
        checkOutput("abort_busy_cycles", 64'(cyc), 64'd11);
        checkOutput("abort_outputs", 64'({a_busy, a_done, a_rd_en, a_wr_en}), 64'd0);
        checkOutput("abort_sb_drained", 64'(sb_q.size()), 64'd0);
        pushMarch(24);
        applyStimulus(0, 1'b1, 1'b0);
        runAndCount(0, 100, -1, -1, cyc);
        checkOutput("post_abort_busy_cycles", 64'(cyc), 64'd28);
        checkOutput("post_abort_done", 64'({a_done, a_fail}), 64'({1'b1, 1'b0}));

        $display("[TB] asynchronous reset during M2");
        pushMarch(24);
        applyStimulus(0, 1'b1, 1'b0);
        n = 0;
        while ((a_cur_elem != 2'd2) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_m2", 64'(a_cur_elem), 64'd2);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_state", 64'(stateVecA()), 64'(RESET_VEC));
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pushMarch(24);
        applyStimulus(0, 1'b1, 1'b0);
        runAndCount(0, 100, -1, -1, cyc);
        checkOutput("post_reset_busy_cycles", 64'(cyc), 64'd28);
        checkOutput("post_reset_done", 64'({a_done, a_fail}), 64'({1'b1, 1'b0}));
        checkOutput("post_reset_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] stop on first failure");
        applyStimulus(1, 1'b1, 1'b0);
        runAndCount(1, 100, -1, -1, cyc);
        checkOutput("stop_busy_cycles", 64'(cyc), 64'd10);
        checkOutput("stop_done_fail", 64'({s_done, s_fail}), 64'({1'b1, 1'b1}));
        checkOutput("stop_count", 64'(s_fail_count), 64'd1);
        checkOutput("stop_addr", 64'(s_fail_addr), 64'd2);
        checkOutput("stop_syndrome", 64'(s_fail_syndrome), 64'h01);
        checkOutput("stop_last_write_issued", 64'(mem_s[2]), 64'hFF);
        checkOutput("stop_no_later_write", 64'(mem_s[3]), 64'h00);

        $display("[TB] saturating failure counter");
        applyStimulus(2, 1'b1, 1'b0);
        runAndCount(2, 3000, -1, -1, cyc);
        checkOutput("sat_busy_cycles", 64'(cyc), 64'd1792);
        checkOutput("sat_count", 64'(w_fail_count), 64'd255);
        checkOutput("sat_done_fail", 64'({w_done, w_fail}), 64'({1'b1, 1'b1}));
        checkOutput("sat_addr", 64'(w_fail_addr), 64'd0);
        checkOutput("sat_syndrome", 64'(w_fail_syndrome), 64'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
